// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm controller: programmable alarm time, ring with 1 Hz beep, snooze/stop/timeout
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [9:0]  msec_i,
    input  logic [5:0]  sec_i,
    input  logic [5:0]  min_i,
    input  logic [4:0]  hour_i,
    input  logic        set_i,
    input  logic [4:0]  alarm_hour_i,
    input  logic [5:0]  alarm_min_i,
    input  logic        enable_i,
    input  logic        snooze_i,
    input  logic        stop_i,
    output logic [4:0]  alarm_hour_o,
    output logic [5:0]  alarm_min_o,
    output logic        armed_o,
    output logic        ringing_o,
    output logic        beep_o,
    output logic [1:0]  snooze_cnt_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [5:0] RING_LAST   = 6'(RING_SEC - 1);
    localparam logic [5:0] SNOOZE_LAST = 6'(SNOOZE_MIN - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t      state_q, state_nx;
    logic [4:0]  alarm_hour_q;
    logic [5:0]  alarm_min_q;
    logic [5:0]  ring_cnt_q, ring_cnt_nx;
    logic [5:0]  min_cnt_q, min_cnt_nx;
    logic [1:0]  snooze_cnt_q, snooze_cnt_nx;
    logic [5:0]  sec_q, min_q;
    logic        match, match_q, trigger;
    logic        sec_tick, min_tick;
    logic        set_ok;
    logic        beep_q, err_q;

    assign set_ok   = (alarm_hour_i <= 5'd23) && (alarm_min_i <= 6'd59);
    assign match    = (hour_i == alarm_hour_q) && (min_i == alarm_min_q) &&
                      (sec_i == 6'd0) && (msec_i == 10'd0);
    // Edge-detect the match so a time held at hh:mm:00.000 fires only once
    assign trigger  = match & ~match_q;
    assign sec_tick = (sec_i != sec_q);
    assign min_tick = (min_i != min_q);

    always_comb begin
        state_nx      = state_q;
        ring_cnt_nx   = ring_cnt_q;
        min_cnt_nx    = min_cnt_q;
        snooze_cnt_nx = snooze_cnt_q;
        if (!enable_i) begin
            state_nx      = IDLE;
            snooze_cnt_nx = 2'd0;
        end else begin
            case (state_q)
                IDLE: state_nx = ARMED;
                ARMED: begin
                    if (trigger && !set_i && !stop_i) begin
                        state_nx      = RINGING;
                        ring_cnt_nx   = 6'd0;
                        snooze_cnt_nx = 2'd0;
                    end
                end
                RINGING: begin
                    if (set_i || stop_i) begin
                        state_nx = ARMED;
                    end else if (snooze_i) begin
                        if (snooze_cnt_q < SNOOZE_MAX) begin
                            state_nx      = SNOOZE;
                            snooze_cnt_nx = snooze_cnt_q + 2'd1;
                            min_cnt_nx    = 6'd0;
                        end else begin
                            state_nx = ARMED;
                        end
                    end else if (sec_tick) begin
                        if (ring_cnt_q == RING_LAST) state_nx = ARMED;
                        else                         ring_cnt_nx = ring_cnt_q + 6'd1;
                    end
                end
                SNOOZE: begin
                    if (set_i || stop_i) begin
                        state_nx = ARMED;
                    end else if (min_tick) begin
                        if (min_cnt_q == SNOOZE_LAST) begin
                            state_nx    = RINGING;
                            ring_cnt_nx = 6'd0;
                        end else begin
                            min_cnt_nx = min_cnt_q + 6'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        // Any return to ARMED ends the alarm event
        if (state_nx == ARMED && state_q != ARMED) snooze_cnt_nx = 2'd0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            alarm_hour_q <= 5'd0;
            alarm_min_q  <= 6'd0;
            ring_cnt_q   <= 6'd0;
            min_cnt_q    <= 6'd0;
            snooze_cnt_q <= 2'd0;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            match_q      <= 1'b0;
            beep_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_nx;
            ring_cnt_q   <= ring_cnt_nx;
            min_cnt_q    <= min_cnt_nx;
            snooze_cnt_q <= snooze_cnt_nx;
            sec_q        <= sec_i;
            min_q        <= min_i;
            match_q      <= match;
            beep_q       <= (state_nx == RINGING) && (msec_i < 10'd500);
            err_q        <= set_i && !set_ok;
            if (set_i && set_ok) begin
                alarm_hour_q <= alarm_hour_i;
                alarm_min_q  <= alarm_min_i;
            end
        end
    end

    assign alarm_hour_o = alarm_hour_q;
    assign alarm_min_o  = alarm_min_q;
    assign armed_o      = (state_q != IDLE);
    assign ringing_o    = (state_q == RINGING);
    assign beep_o       = beep_q;
    assign snooze_cnt_o = snooze_cnt_q;
    assign err_o        = err_q;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller that consumes the running time-of-day (msec/sec/min/hour) produced by the clock counter block.
- Holds a programmable alarm time and raises a ringing indication with a 1 Hz beep pattern when the time matches.
- Supports snooze, stop and auto-timeout, and exposes status for the display/top level.

Parameters:
- RING_SEC, 60, seconds a ring lasts before auto-stop (1..63)
- SNOOZE_MIN, 5, minutes of silence after a snooze (1..63)
- MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze acts as stop

Ports:
- clk_i  in  1  system clock, 50 MHz
- rst_i  in  1  asynchronous reset, active-low
- msec_i  in  10  current milliseconds, 0..999
- sec_i  in  6  current seconds, 0..59
- min_i  in  6  current minutes, 0..59
- hour_i  in  5  current hours, 0..23
- set_i  in  1  one-cycle pulse: load alarm_hour_i/alarm_min_i
- alarm_hour_i  in  5  alarm hour to load
- alarm_min_i  in  6  alarm minute to load
- enable_i  in  1  level: alarm armed when 1
- snooze_i  in  1  one-cycle pulse
- stop_i  in  1  one-cycle pulse
- alarm_hour_o  out  5  stored alarm hour
- alarm_min_o  out  6  stored alarm minute
- armed_o  out  1  state is ARMED, RINGING or SNOOZE
- ringing_o  out  1  state is RINGING
- beep_o  out  1  audible drive, registered
- snooze_cnt_o  out  2  snoozes used in the current event
- err_o  out  1  one-cycle pulse: rejected set

Behaviour:
- Reset (rst_i=0, async) values:
  - alarm_hour_o=0, alarm_min_o=0.
  - State IDLE: armed_o=0, ringing_o=0, beep_o=0.
  - snooze_cnt_o=0, err_o=0, internal counters 0, sampled-input registers 0.
- Set:
  - If alarm_hour_i<=23 and alarm_min_i<=59: load the registers, visible next cycle.
  - Otherwise keep the old values and pulse err_o=1 for exactly one cycle.
  - Legal in any state. A set during RINGING/SNOOZE also ends the event: go to ARMED (if enable_i) and clear snooze_cnt_o.
- Match:
  - match = (hour_i==alarm_hour_o)&&(min_i==alarm_min_o)&&(sec_i==0)&&(msec_i==0), computed combinationally.
  - match_q is a registered copy of match.
  - trigger = match & ~match_q, so only one trigger fires per 1 ms window.
- Ticks:
  - sec_q and min_q are registered copies of the inputs.
  - sec_tick = (sec_i!=sec_q).
  - min_tick = (min_i!=min_q).
- FSM (all transitions registered; ringing_o rises the cycle after trigger is seen):
  - IDLE: enable_i=1 -> ARMED.
  - ARMED: enable_i=0 -> IDLE. trigger -> RINGING, clearing ring_cnt and snooze_cnt_o.
  - RINGING:
    - stop_i -> ARMED.
    - snooze_i with snooze_cnt_o<MAX_SNOOZE -> SNOOZE, incrementing snooze_cnt_o and clearing min_cnt.
    - snooze_i with snooze_cnt_o==MAX_SNOOZE -> ARMED, as for stop.
    - ring_cnt increments on each sec_tick; sec_tick with ring_cnt==RING_SEC-1 -> ARMED.
  - SNOOZE:
    - stop_i -> ARMED.
    - min_cnt increments on each min_tick; min_tick with min_cnt==SNOOZE_MIN-1 -> RINGING, clearing ring_cnt.
  - enable_i=0 in any state -> IDLE next cycle, with snooze_cnt_o cleared. This has the highest priority.
  - Priority: enable_i low > set > stop_i > snooze_i > timers/trigger.
  - On entering ARMED from any state, snooze_cnt_o is cleared.
- Beep:
  - beep_o <= (next state is RINGING) && (msec_i<500).
  - It is registered, so it lags msec_i by one cycle. It is 0 in all other states.
- Snooze with snooze_cnt_o==MAX_SNOOZE: snooze_cnt_o saturates; no wrap.
- Clock input wrap 23:59:59.999 -> 00:00:00.000 needs no special handling; matching is by equality only.
- Reset asserted mid-ring: outputs drop immediately, asynchronously.

Test Plan:
- Set 07:30, enable_i=1, drive time 07:29:59.999 -> 07:30:00.000 -> ringing_o=1 one cycle later; beep_o=1 for msec 0..499, 0 for 500..999.
- Ringing, no input -> ringing_o falls on the 60th sec_tick (time 07:31:00.000 +1 cycle); armed_o stays 1; no re-trigger while msec_i holds 0 for 50000 cycles.
- Ringing, snooze_i -> SNOOZE, snooze_cnt_o=1, beep_o=0; after 5 min_ticks (07:35:xx) -> ringing_o=1. Fourth snooze after 3 used -> armed_o=1, ringing_o=0, snooze_cnt_o=0.
- set_i with hour=24, min=10 -> err_o pulses 1 cycle, alarm_hour_o/min_o unchanged. set_i with min=60 -> same.
- Ringing, enable_i=0 -> IDLE next cycle, all outputs 0 except the stored alarm time. Re-enabling at a non-matching time does not ring.
- Assert rst_i=0 mid-ring, asynchronously between clock edges -> all outputs at reset values before the next edge; after release the block stays IDLE until enable_i.
